// File: rtl/wb8_arbiter2_pkg.sv
// wb8_arbiter2_pkg: state encodings and default watchdog limit shared by the
// two-master byte-wide Wishbone arbiter.
package wb8_arbiter2_pkg;
    localparam logic [1:0]  ARB_IDLE    = 2'd0;
    localparam logic [1:0]  ARB_GNT0    = 2'd1;
    localparam logic [1:0]  ARB_GNT1    = 2'd2;
    localparam logic [15:0] ARB_TIMEOUT = 16'd256;
endpackage

// File: rtl/wb8_watchdog.sv
// wb8_watchdog: counts granted cycles that wait for ACK and flags the last
// allowed one; the flag is decoded from the registered count.
module wb8_watchdog
    import wb8_arbiter2_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = ARB_TIMEOUT,
    parameter int unsigned CNT_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic ack,
    input  logic clr,
    output logic err
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 16'd1);
    logic [CNT_W-1:0] cnt;
    assign err = (TIMEOUT != 16'd0) && en && !ack && (cnt == LAST);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (TIMEOUT == 16'd0 || clr || ack || !en) ? '0 : cnt + CNT_W'(1);
endmodule

// File: rtl/wb8_arbiter2.sv
// wb8_arbiter2: round-robin arbiter letting two byte-wide pipelined Wishbone
// masters share one slave; grant is held for a whole CYC, with an ACK watchdog.
module wb8_arbiter2
    import wb8_arbiter2_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = ARB_TIMEOUT,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        M0_CYC_I,
    input  logic        M0_STB_I,
    input  logic        M0_WE_I,
    input  logic [31:0] M0_ADR_I,
    input  logic [7:0]  M0_DAT_I,
    output logic [7:0]  M0_DAT_O,
    output logic        M0_ACK_O,
    output logic        M0_STALL_O,
    output logic        M0_ERR_O,
    input  logic        M1_CYC_I,
    input  logic        M1_STB_I,
    input  logic        M1_WE_I,
    input  logic [31:0] M1_ADR_I,
    input  logic [7:0]  M1_DAT_I,
    output logic [7:0]  M1_DAT_O,
    output logic        M1_ACK_O,
    output logic        M1_STALL_O,
    output logic        M1_ERR_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [31:0] ADR_O,
    output logic [7:0]  DAT_O,
    input  logic [7:0]  DAT_I,
    input  logic        ACK_I,
    input  logic        STALL_I,
    output logic [1:0]  O_grant
);
    logic [1:0] state, state_nxt;
    logic       last, g0, g1, err;
    assign g0 = state == ARB_GNT0;
    assign g1 = state == ARB_GNT1;
    // A watchdog expiry forces IDLE so the other master wins the next contest.
    assign state_nxt = g0 ? (err ? ARB_IDLE : M0_CYC_I ? ARB_GNT0 : M1_CYC_I ? ARB_GNT1 : ARB_IDLE) :
                       g1 ? (err ? ARB_IDLE : M1_CYC_I ? ARB_GNT1 : M0_CYC_I ? ARB_GNT0 : ARB_IDLE) :
                       (M0_CYC_I && M1_CYC_I) ? (last ? ARB_GNT0 : ARB_GNT1) :
                       M0_CYC_I ? ARB_GNT0 : M1_CYC_I ? ARB_GNT1 : ARB_IDLE;
    always_ff @(posedge CLK_I or negedge RST_I)
        if (!RST_I) begin
            state <= ARB_IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= state_nxt == ARB_GNT1 ? 1'b1 : state_nxt == ARB_GNT0 ? 1'b0 : last;
        end
    wb8_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wdog (
        .clk   (CLK_I),
        .rst_n (RST_I),
        .en    ((g0 || g1) && CYC_O),
        .ack   (ACK_I),
        .clr   (state_nxt != state || !(g0 || g1)),
        .err   (err)
    );
    assign CYC_O      = g0 ? M0_CYC_I : g1 ? M1_CYC_I : 1'b0;
    assign STB_O      = g0 ? M0_STB_I : g1 ? M1_STB_I : 1'b0;
    assign WE_O       = g0 ? M0_WE_I  : g1 ? M1_WE_I  : 1'b0;
    assign ADR_O      = g0 ? M0_ADR_I : g1 ? M1_ADR_I : 32'd0;
    assign DAT_O      = g0 ? M0_DAT_I : g1 ? M1_DAT_I : 8'd0;
    assign M0_DAT_O   = DAT_I;
    assign M1_DAT_O   = DAT_I;
    assign M0_ACK_O   = g0 && ACK_I;
    assign M1_ACK_O   = g1 && ACK_I;
    assign M0_ERR_O   = g0 && err;
    assign M1_ERR_O   = g1 && err;
    assign M0_STALL_O = g0 ? STALL_I : M0_STB_I;
    assign M1_STALL_O = g1 ? STALL_I : M1_STB_I;
    assign O_grant    = {g1, g0};
endmodule

// File: tb/tb_wb8_arbiter2.sv
// tb_wb8_arbiter2: directed vector table plus hand-written transfer sequences
// against a small byte-wide memory slave.
module tb_wb8_arbiter2;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [31:0] m0_adr = 0, m1_adr = 0;
    logic [7:0]  m0_wd = 0, m1_wd = 0, m0_rd, m1_rd;
    logic        m0_ack, m0_stall, m0_err, m1_ack, m1_stall, m1_err;
    logic        cyc, stb, we, ack, stall;
    logic [31:0] adr;
    logic [7:0]  wdat, rdat;
    logic [1:0]  grant;
    logic        use_model = 0, ack_en = 1, mem_init = 0, t_ack = 0, t_stall = 0;
    logic [7:0]  t_dat = 0, s_dat;
    logic        s_ack;
    logic [7:0]  mem [0:7];
    int          n_cmp = 0, n_bad = 0, m1_ack_cnt = 0;

    always #5 clk = ~clk;

    wb8_arbiter2 #(.TIMEOUT(16'd8), .CNT_W(16)) dut (
        .CLK_I(clk), .RST_I(rst_n),
        .M0_CYC_I(m0_cyc), .M0_STB_I(m0_stb), .M0_WE_I(m0_we), .M0_ADR_I(m0_adr), .M0_DAT_I(m0_wd),
        .M0_DAT_O(m0_rd), .M0_ACK_O(m0_ack), .M0_STALL_O(m0_stall), .M0_ERR_O(m0_err),
        .M1_CYC_I(m1_cyc), .M1_STB_I(m1_stb), .M1_WE_I(m1_we), .M1_ADR_I(m1_adr), .M1_DAT_I(m1_wd),
        .M1_DAT_O(m1_rd), .M1_ACK_O(m1_ack), .M1_STALL_O(m1_stall), .M1_ERR_O(m1_err),
        .CYC_O(cyc), .STB_O(stb), .WE_O(we), .ADR_O(adr), .DAT_O(wdat),
        .DAT_I(rdat), .ACK_I(ack), .STALL_I(stall), .O_grant(grant)
    );

    assign ack   = use_model ? s_ack : t_ack;
    assign stall = use_model ? 1'b0 : t_stall;
    assign rdat  = use_model ? s_dat : t_dat;

    // Memory slave: accepts every strobe, acks one cycle later.
    always @(posedge clk) begin
        s_ack <= use_model && ack_en && cyc && stb && !stall;
        s_dat <= mem[adr[2:0]];
        if (mem_init)
            for (int i = 0; i < 8; i++) mem[i] <= (i < 4) ? 8'(i) : 8'(8'h80 + i - 4);
        else if (use_model && cyc && stb && !stall && we)
            mem[adr[2:0]] <= wdat;
    end

    always @(posedge clk) if (m1_ack) m1_ack_cnt <= m1_ack_cnt + 1;

    typedef struct packed {
        logic       c0, s0, c1, s1, ak, st;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic xfer(input int m, input logic w, input logic [31:0] a, input logic [7:0] d,
                        output logic [7:0] r);
        bit ok = 0;
        r = 8'h00;
        if (m == 0) begin m0_stb = 1; m0_we = w; m0_adr = a; m0_wd = d; end
        else begin m1_stb = 1; m1_we = w; m1_adr = a; m1_wd = d; end
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (!(m == 0 ? m0_stall : m1_stall)) ok = 1;
            else @(negedge clk);
        end
        chk("accept_wait", 64'(ok), 64'd1);
        @(negedge clk);
        if (m == 0) m0_stb = 0; else m1_stb = 0;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (m == 0 ? m0_ack : m1_ack) begin r = m == 0 ? m0_rd : m1_rd; ok = 1; end
            else @(negedge clk);
        end
        chk("ack_wait", 64'(ok), 64'd1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  b;
        logic [31:0] word, wv;
        logic [9:0]  errv;
        logic [19:0] gv;
        int          base;
        tbl = '{
            {6'b000000, 8'b00000000}, {6'b111110, 8'b00001100}, {6'b111101, 8'b01111100},
            {6'b101110, 8'b01100110}, {6'b001110, 8'b01000110}, {6'b111100, 8'b10111000},
            {6'b111010, 8'b10101001}, {6'b110000, 8'b10001000}, {6'b000000, 8'b01000000},
            {6'b111100, 8'b00001100}, {6'b111100, 8'b10111000}, {6'b110000, 8'b10001000},
            {6'b000000, 8'b01000000}, {6'b001100, 8'b00000100}, {6'b000000, 8'b10000000},
            {6'b111100, 8'b00001100}, {6'b000000, 8'b01000000}, {6'b000000, 8'b00000000}};
        // Reset state: requests and ACK present but nothing granted or forwarded.
        m0_cyc = 1; m0_stb = 1; t_ack = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", {58'd0, grant, cyc, stb, m0_ack, m0_err}, 64'd0);
        chk("reset_stall_follows_stb", {62'd0, m0_stall, m1_stall}, 64'b10);
        m0_cyc = 0; m0_stb = 0; t_ack = 0;
        rst_n = 1;
        m0_we = 1; m0_adr = 32'h2; m0_wd = 8'hA5;
        m1_we = 0; m1_adr = 32'h4; m1_wd = 8'h5A;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            {m0_cyc, m0_stb, m1_cyc, m1_stb, t_ack, t_stall} = {tbl[i].c0, tbl[i].s0, tbl[i].c1,
                                                                tbl[i].s1, tbl[i].ak, tbl[i].st};
            #1;
            chk($sformatf("vec%0d", i), {56'd0, grant, cyc, stb, m0_stall, m1_stall, m0_ack, m1_ack},
                {56'd0, tbl[i].exp});
            if (tbl[i].exp[7:6] != 2'b00)
                chk($sformatf("vec%0d_bus", i), {23'd0, we, adr, wdat},
                    tbl[i].exp[6] ? {23'd0, 1'b1, 32'h2, 8'hA5} : {23'd0, 1'b0, 32'h4, 8'h5A});
        end
        t_dat = 8'h3C;
        #1;
        chk("dat_passthrough", {48'd0, m0_rd, m1_rd}, {48'd0, 16'h3C3C});
        @(negedge clk);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; m0_we = 0; m1_we = 0;
        use_model = 1; mem_init = 1;
        @(negedge clk);
        mem_init = 0;
        // Master 0 alone: word read at address 2.
        @(negedge clk);
        m0_cyc = 1;
        #1 chk("a_grant_latency0", 64'(grant), 64'd0);
        @(negedge clk);
        #1 chk("a_grant_latency1", 64'(grant), 64'b01);
        @(negedge clk);
        base = m1_ack_cnt;
        word = 0;
        for (int k = 0; k < 4; k++) begin xfer(0, 0, 32'(2 + k), 8'h00, b); word[8*k+:8] = b; end
        chk("a_read_word", 64'(word), 64'h81800302);
        chk("a_m1_ack_quiet", 64'(m1_ack_cnt), 64'(base));
        m0_cyc = 0;
        // Simultaneous request after reset, then seamless handoff.
        do_reset();
        @(negedge clk);
        m0_cyc = 1; m1_cyc = 1; m1_stb = 1; m1_adr = 32'h4;
        @(negedge clk);
        #1 chk("b_m0_first", 64'(grant), 64'b01);
        chk("b_m1_stalled", 64'(m1_stall), 64'd1);
        @(negedge clk);
        xfer(0, 0, 32'h0, 8'h00, b);
        chk("b_m0_byte", 64'(b), 64'h00);
        m0_cyc = 0;
        #1 chk("b_handoff_pre", 64'(grant), 64'b01);
        @(negedge clk);
        #1 chk("b_handoff_no_idle", 64'(grant), 64'b10);
        xfer(1, 0, 32'h4, 8'h00, b);
        chk("b_m1_byte", 64'(b), 64'h80);
        m1_cyc = 0;
        // Write contention: M1 strobes throughout M0's word write.
        @(negedge clk);
        m0_cyc = 1; m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0;
        @(negedge clk);
        #1 chk("c_rr_m0_after_m1", 64'(grant), 64'b01);
        @(negedge clk);
        wv = 32'hCAFEBEEF;
        for (int k = 0; k < 4; k++) begin
            xfer(0, 1, 32'(k), wv[8*k+:8], b);
            #1 chk($sformatf("c_m1_stall%0d", k), 64'(m1_stall), 64'd1);
        end
        m0_cyc = 0;
        word = 0;
        for (int k = 0; k < 4; k++) begin xfer(1, 0, 32'(k), 8'h00, b); word[8*k+:8] = b; end
        chk("c_m1_readback", 64'(word), 64'hCAFEBEEF);
        m1_cyc = 0;
        // Watchdog: slave never acks, M1 pending.
        @(negedge clk);
        ack_en = 0;
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h0; m1_cyc = 1; m1_stb = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            errv[i] = m0_err;
            gv[2*i+:2] = grant;
            chk($sformatf("d_m1_err%0d", i), 64'(m1_err), 64'd0);
        end
        chk("d_err_pulse", 64'(errv), 64'b0010000000);
        chk("d_grant_seq", 64'(gv), 64'b10_00_01_01_01_01_01_01_01_01);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        @(negedge clk);
        ack_en = 1;
        // Asynchronous reset in the middle of a four-byte burst.
        @(negedge clk);
        m0_cyc = 1;
        @(negedge clk);
        xfer(0, 0, 32'h0, 8'h00, b);
        xfer(0, 0, 32'h1, 8'h00, b);
        m0_stb = 1; m0_adr = 32'h2; m1_cyc = 1;
        #1 chk("e_pre_reset_bus", {62'd0, cyc, stb}, 64'b11);
        #2 rst_n = 0;
        #1 chk("e_reset_drop", {59'd0, grant, cyc, stb, m0_err}, 64'd0);
        @(negedge clk);
        rst_n = 1; m0_stb = 0;
        @(negedge clk);
        #1 chk("e_post_reset_m0_first", 64'(grant), 64'b01);
        m0_cyc = 0; m1_cyc = 0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb8_arbiter2.md
Name: wb8_arbiter2

Overview:
Two-master, one-slave arbiter for the 8-bit pipelined Wishbone bus produced by bus_wb8. It lets the CPU bus adapter (master 0) and a second byte-wide master (master 1, e.g. a DMA or video fetcher) share one slave, such as bram_wb8. Grant is held for a whole CYC cycle and rotates round-robin. A watchdog terminates transfers that never receive ACK.

Parameters:
TIMEOUT, 16'd256, cycles a granted strobe may wait for ACK_I before error termination; 0 disables the watchdog
CNT_W, 16, width of the watchdog counter; TIMEOUT must fit in it

Ports:
CLK_I  in  1  system clock, all state on rising edge
RST_I  in  1  reset, asynchronous, active-low
M0_CYC_I  in  1  master 0 cycle request
M0_STB_I  in  1  master 0 strobe
M0_WE_I  in  1  master 0 write enable
M0_ADR_I  in  32  master 0 address
M0_DAT_I  in  8  master 0 write data
M0_DAT_O  out  8  read data to master 0
M0_ACK_O  out  1  acknowledge to master 0
M0_STALL_O  out  1  stall to master 0
M0_ERR_O  out  1  watchdog error to master 0
M1_* (CYC_I, STB_I, WE_I, ADR_I, DAT_I, DAT_O, ACK_O, STALL_O, ERR_O): identical set for master 1
CYC_O  out  1  slave cycle
STB_O  out  1  slave strobe
WE_O  out  1  slave write enable
ADR_O  out  32  slave address
DAT_O  out  8  slave write data
DAT_I  in  8  slave read data
ACK_I  in  1  slave acknowledge
STALL_I  in  1  slave stall
O_grant  out  2  one-hot current grant (00 = idle)

Behaviour:
- States: IDLE, GNT0, GNT1. Reset → IDLE, last_grant = 1, counter = 0. All outputs 0 in reset, except Mx_STALL_O, which follows its STB rule below.
- IDLE: CYC_O = STB_O = 0, O_grant = 00. On an edge where only Mx_CYC_I is high → GNTx. When both are high → the master ≠ last_grant wins. Arbitration latency is one cycle: the slave sees the first STB in the cycle after the grant registers.
- GNTx: CYC_O, STB_O, WE_O, ADR_O and DAT_O are a combinational mux from master x. Mx_STALL_O = STALL_I, Mx_ACK_O = ACK_I, Mx_ERR_O = watchdog error. last_grant <= x on entry.
- Non-granted master (or any master in IDLE): STALL_O = its own STB_I, ACK_O = 0, ERR_O = 0. Its strobes are never accepted.
- Both Mx_DAT_O always carry DAT_I. Masters qualify data with ACK.
- Release: in GNTx, when Mx_CYC_I = 0 at the edge → GNTy if My_CYC_I = 1, else IDLE. There is no idle gap on handoff. A master keeping CYC high keeps the grant indefinitely; there is no preemption.
- Watchdog (TIMEOUT ≠ 0): the counter increments each granted cycle with CYC_O = 1 and ACK_I = 0. It clears on ACK_I, on any state change, and in IDLE. When counter == TIMEOUT-1 and ACK_I = 0: Mx_ERR_O pulses for 1 cycle (registered, combinational to state), the next state is IDLE, and last_grant = x. Master x must drop CYC. If it re-requests while the other master is requesting, the other master wins.
- ACK_I while in IDLE (stray) is ignored and not forwarded.
- ACK_I and CYC drop on the same edge: the ACK is delivered and the release still happens.
- Async reset mid-transfer: the grant drops immediately, CYC_O = STB_O = 0 without waiting for ACK, and no ERR is raised.

Decomposition:
- Shared package/header (beside busdefs.vh): state encodings ARB_IDLE/ARB_GNT0/ARB_GNT1 and the default TIMEOUT constant.
- Sub-module wb8_watchdog (counter, compare, error pulse; inputs en/ack/clr) is natural. The rest stays in wb8_arbiter2.

Test Plan:
- Master 0 alone: M0 READW through bus_wb8 at addr 2 against bram_wb8 init 00 01 02 03 80 81 82 83 → O_grant = 01 one cycle after CYC, data 32'h81800302, M1_ACK_O never 1.
- Simultaneous CYC from both after reset → GNT0 first. When M0 drops CYC, GNT1 on that same edge with no IDLE cycle; M1 byte read at addr 4 returns 8'h80.
- Round robin: M1 served last, then both request → M0 granted; M0 served last, then both request → M1 granted.
- Write contention: M0 WRITEW 32'hCAFEBEEF at addr 0 while M1 strobes → M1_STALL_O = 1 throughout. M1 later reads addr 0..3 → EF BE FE CA.
- Watchdog with TIMEOUT = 8 and a dummy slave never asserting ACK → M0_ERR_O high for exactly 1 cycle on the 8th waiting cycle, then O_grant = 00, and a pending M1 is granted next.
- RST_I pulled low mid-burst (after 2 of 4 ACKs) → CYC_O/STB_O/O_grant go to 0 immediately with no ERR. After release, grant order restarts with M0 priority.
